mem_burst_ctrl: RTL
===================

# mem_burst_ctrl

Parametrised burst memory controller for the crossbar output path. It arbitrates among `NUM_CH` requesters and grants one channel at a time. For each grant it drives a chip-enable, a start strobe and a burst of `BURST_LEN` consecutive addresses. Each channel owns a private address region with its own wrap-around pointer, and a `hold` input stalls the burst mid-stream. This block supersedes the fixed 4-beat, single-counter output controller.

## Interface
- `ADDR_W`, 10: total address width.
- `NUM_CH`, 4: number of requesting channels; power of two, ≥2. `CH_W = $clog2(NUM_CH)`.
- `BURST_LEN`, 4: beats per burst; power of two, 2 ≤ BURST_LEN ≤ 2^(ADDR_W−CH_W).

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NUM_CH: per-channel burst request, level-sampled in IDLE.
- `hold` input 1: stall the burst; honoured only in BURST.
- `cen` output 1: memory chip enable.
- `start` output 1: beat-valid strobe; `addr` is valid when this is high.
- `addr` output ADDR_W: `{ch_id, offset}`.
- `grant` output NUM_CH: one-hot granted channel, held for the whole transaction.
- `ch_id` output CH_W: binary index of the granted channel.
- `done` output 1: one-cycle pulse coincident with the last beat.

## Operation
- **States:** IDLE, ARM, BURST.
- **IDLE:**
  - Outputs: `cen=0`, `start=0`, `done=0`, `grant=0`.
  - If `req != 0`, arbitrate, register `grant` and `ch_id`, set `cen=1`, and go to ARM.
- **ARM:**
  - Outputs: `cen=1`, `start=0`.
  - `addr = {ch_id, ptr[ch_id]}`. Beat counter cleared.
  - Unconditionally go to BURST.
- **BURST:**
  - Outputs: `cen=1`, `start = !hold`.
  - `addr = {ch_id, ptr[ch_id] + beat}`; the offset arithmetic is modulo 2^(ADDR_W−CH_W).
  - While `hold=1`, `beat` and `addr` freeze and `start=0`.
  - When `beat == BURST_LEN−1` and `hold=0`:
    - `done=1` this cycle.
    - At the next edge: `ptr[ch_id] += BURST_LEN` (wraps modulo region size), and `cen`, `grant` clear.
    - Go to IDLE.
- **Pointers:** one `ptr[ch]` of width ADDR_W−CH_W per channel; only the granted channel's pointer advances.
- **Request changes:** `req` changes after the grant are ignored; the burst always completes. `hold` is ignored in IDLE and ARM.
- **Arbitration (default, macro absent):** fixed priority, lowest index wins.

## Timing
- **Reset:** all outputs 0, all `ptr` = 0, state IDLE, round-robin pointer 0.
- **Mid-transaction reset:** `rst` high during any state aborts the transaction; outputs are 0 at the next edge.
- **Request to first beat:** `req` sampled at edge N (in IDLE).
  - Edges N+1 and later: `cen=1`, grant valid (ARM cycle).
  - Edge N+2: first `start`.
  - With no hold, beats occupy N+2 … N+1+BURST_LEN.
  - `done` is high in the cycle of beat BURST_LEN−1.
  - `cen` is 0 from N+2+BURST_LEN.
- **Added latency:** each `hold` cycle adds exactly one cycle to the burst.
- **Back-to-back:** a new grant can be taken in the IDLE cycle right after `done`. Minimum gap between bursts is 2 cycles without `start` (IDLE + ARM).

## Configuration
- `MEM_BURST_RR_EN` defined:
  - Arbitration is round-robin.
  - After a grant to channel k, priority order becomes k+1, k+2, … (mod NUM_CH).
  - The round-robin pointer updates at the grant.
- `MEM_BURST_RR_EN` absent:
  - Fixed priority, lowest index wins.
  - No round-robin state is synthesised.

## Test plan
- **Single burst:** defaults, `req=4'b0001` for one cycle after reset.
  - `cen` rises at +1.
  - `start` is high +2…+5 with `addr` 0,1,2,3.
  - `done` at +5; `ptr[0]=4`.
- **Channel region:** `req=4'b0100`, run twice.
  - Addresses 0x200–0x203, then 0x204–0x207.
  - `ch_id=2`, `grant=4'b0100`.
- **Hold stall:** assert `hold` on the 2nd beat for 3 cycles.
  - `addr` frozen at offset 1 with `start=0`.
  - Burst completes 3 cycles later; 4 beats total.
- **Pointer wrap:** pre-drive channel 1 through 64 bursts (256 beats).
  - The 65th burst emits 0x100–0x103; offset wraps to 0.
- **Arbitration:** hold `req=4'b1111` for 4 bursts.
  - Without macro: grants 0,0,0,0.
  - With `MEM_BURST_RR_EN`: grants 0,1,2,3.
- **Reset mid-burst:** pulse `rst` on the 3rd beat.
  - Next edge: all outputs 0 and `ptr[0]=0`.
  - A subsequent request restarts at `addr` 0.

Source files
------------

// File: rtl/mem_burst_ctrl_if.sv
// Request/burst bus between channel requesters and mem_burst_ctrl.
// The master side drives req/hold; the slave (controller) drives the memory strobes.
interface mem_burst_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] req;
    logic              hold;
    logic              cen;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   ch_id;
    logic              done;

    modport master (
        output req, hold,
        input  cen, start, addr, grant, ch_id, done
    );

    modport slave (
        input  req, hold,
        output cen, start, addr, grant, ch_id, done
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: arbitrates NUM_CH requesters, emits BURST_LEN beats per grant
// from a per-channel wrapping pointer. Define MEM_BURST_RR_EN for round-robin arbitration.
module mem_burst_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int NUM_CH    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_burst_ctrl_if.slave bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int OFF_W  = ADDR_W - CH_W;
    localparam int BEAT_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        BURST
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [CH_W-1:0]   ch_id_q, ch_id_d;
    logic [OFF_W-1:0]  ptr_q [NUM_CH];
    logic [OFF_W-1:0]  ptr_d [NUM_CH];

    logic [CH_W-1:0]   arb_base;
    logic [CH_W-1:0]   arb_idx;
    logic [CH_W-1:0]   cand;
    logic              arb_found;
    logic [OFF_W-1:0]  offset;
    logic              last_beat;

`ifdef MEM_BURST_RR_EN
    logic [CH_W-1:0] rr_q, rr_d;
    assign arb_base = rr_q;
`else
    assign arb_base = '0;
`endif

    // Scan from arb_base upward; power-of-two NUM_CH makes the index wrap for free.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = arb_base + CH_W'(i);
            if (!arb_found && bus.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        grant_d   = grant_q;
        ch_id_d   = ch_id_q;
        ptr_d     = ptr_q;
`ifdef MEM_BURST_RR_EN
        rr_d      = rr_q;
`endif
        offset    = ptr_q[ch_id_q] + OFF_W'(beat_q);
        last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
        bus.cen   = 1'b0;
        bus.start = 1'b0;
        bus.done  = 1'b0;
        bus.addr  = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = ARM;
                    grant_d = NUM_CH'(1) << arb_idx;
                    ch_id_d = arb_idx;
`ifdef MEM_BURST_RR_EN
                    rr_d    = arb_idx + CH_W'(1);
`endif
                end
            end
            ARM: begin
                bus.cen  = 1'b1;
                bus.addr = {ch_id_q, ptr_q[ch_id_q]};
                beat_d   = '0;
                state_d  = BURST;
            end
            BURST: begin
                bus.cen  = 1'b1;
                bus.addr = {ch_id_q, offset};
                if (!bus.hold) begin
                    bus.start = 1'b1;
                    if (last_beat) begin
                        bus.done       = 1'b1;
                        ptr_d[ch_id_q] = ptr_q[ch_id_q] + OFF_W'(BURST_LEN);
                        grant_d        = '0;
                        ch_id_d        = '0;
                        state_d        = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.ch_id = ch_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            grant_q <= '0;
            ch_id_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ptr_q[c] <= '0;
            end
`ifdef MEM_BURST_RR_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            ch_id_q <= ch_id_d;
            ptr_q   <= ptr_d;
`ifdef MEM_BURST_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end
endmodule
